// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: default widths, register-file address encoding
// and the forwarding match rule used by the ID/EX register and the hazard unit.
package cpu_pipe_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_RA_W  = 6;
    localparam int DEF_N_SRC = 2;
    localparam int DEF_N_FWD = 2;

    localparam logic [DEF_RA_W-1:0] ZERO_REG = '0;
    localparam int                  FP_BIT   = DEF_RA_W - 1;

    // Integer x0 never forwards; FP f0 carries FP_BIT so it is not ZERO_REG.
    function automatic logic fwd_hit(
        input logic [DEF_RA_W-1:0] addr,
        input logic                we,
        input logic [DEF_RA_W-1:0] faddr
    );
        return we && (faddr == addr) && (addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/idex_pipe_reg_if.sv
// ID/EX pipeline register bundle: decode-side capture inputs, forwarding sources,
// stall/flush control and the registered EX-slot outputs.
interface idex_pipe_reg_if
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int RA_W  = DEF_RA_W,
    parameter int N_SRC = DEF_N_SRC,
    parameter int N_FWD = DEF_N_FWD
);
    logic                    stall;
    logic                    flush;
    logic                    valid_ID;
    logic [XLEN-1:0]         pc_ID;
    logic [XLEN-1:0]         imm_ID;
    logic [RA_W-1:0]         rd_addr_ID;
    logic [N_SRC*RA_W-1:0]   rs_addr_ID;
    logic [N_SRC*XLEN-1:0]   rs_int_ID;
    logic [N_SRC*XLEN-1:0]   rs_fp_ID;
    logic [N_FWD-1:0]        fwd_we;
    logic [N_FWD*RA_W-1:0]   fwd_addr;
    logic [N_FWD*XLEN-1:0]   fwd_data;

    logic                    valid_EX;
    logic [XLEN-1:0]         pc_EX;
    logic [XLEN-1:0]         imm_EX;
    logic [RA_W-1:0]         rd_addr_EX;
    logic [N_SRC*RA_W-1:0]   rs_addr_EX;
    logic [N_SRC*XLEN-1:0]   op_EX;

    modport master (
        output stall, flush, valid_ID, pc_ID, imm_ID, rd_addr_ID, rs_addr_ID,
               rs_int_ID, rs_fp_ID, fwd_we, fwd_addr, fwd_data,
        input  valid_EX, pc_EX, imm_EX, rd_addr_EX, rs_addr_EX, op_EX
    );

    modport slave (
        input  stall, flush, valid_ID, pc_ID, imm_ID, rd_addr_ID, rs_addr_ID,
               rs_int_ID, rs_fp_ID, fwd_we, fwd_addr, fwd_data,
        output valid_EX, pc_EX, imm_EX, rd_addr_EX, rs_addr_EX, op_EX
    );

endinterface

// File: rtl/idex_opnd_sel.sv
// Operand resolver: priority forward mux (index 0 wins) over int/FP file select by FP_BIT.
// Purely combinational, zero latency; no backpressure, output follows inputs.
module idex_opnd_sel
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int RA_W  = DEF_RA_W,
    parameter int N_FWD = DEF_N_FWD
) (
    input  logic [RA_W-1:0]       addr,
    input  logic [N_FWD-1:0]      fwd_we,
    input  logic [N_FWD*RA_W-1:0] fwd_addr,
    input  logic [N_FWD*XLEN-1:0] fwd_data,
    input  logic [XLEN-1:0]       int_data,
    input  logic [XLEN-1:0]       fp_data,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    // Walk from the oldest source down so the youngest matching one is written last.
    always_comb begin
        hit  = 1'b0;
        data = addr[RA_W-1] ? fp_data : int_data;
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (fwd_hit(addr, fwd_we[k], fwd_addr[k*RA_W +: RA_W])) begin
                hit  = 1'b1;
                data = fwd_data[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with forwarded operand capture; latency 1 cycle ID -> EX.
// stall freezes the slot (operands still refresh from forwards); flush loads a bubble.
module idex_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int RA_W  = DEF_RA_W,
    parameter int N_SRC = DEF_N_SRC,
    parameter int N_FWD = DEF_N_FWD
) (
    input  logic            clk,
    input  logic            rst,
    idex_pipe_reg_if.slave  bus
);

    logic                  valid_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       imm_q;
    logic [RA_W-1:0]       rd_q;
    logic [N_SRC*RA_W-1:0] rs_q;
    logic [N_SRC*XLEN-1:0] op_q;

    logic [N_SRC-1:0]      sel_hit;
    logic [N_SRC*XLEN-1:0] sel_data;

    // One resolver per operand: it looks at the held EX address while stalled
    // (refresh) and at the incoming ID address otherwise (load).
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        logic [RA_W-1:0] sel_addr;

        assign sel_addr = bus.stall ? rs_q[i*RA_W +: RA_W]
                                    : bus.rs_addr_ID[i*RA_W +: RA_W];

        idex_opnd_sel #(
            .XLEN  (XLEN),
            .RA_W  (RA_W),
            .N_FWD (N_FWD)
        ) u_sel (
            .addr     (sel_addr),
            .fwd_we   (bus.fwd_we),
            .fwd_addr (bus.fwd_addr),
            .fwd_data (bus.fwd_data),
            .int_data (bus.rs_int_ID[i*XLEN +: XLEN]),
            .fp_data  (bus.rs_fp_ID[i*XLEN +: XLEN]),
            .hit      (sel_hit[i]),
            .data     (sel_data[i*XLEN +: XLEN])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            op_q    <= '0;
        end else if (bus.stall) begin
            if (valid_q) begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (sel_hit[i]) begin
                        op_q[i*XLEN +: XLEN] <= sel_data[i*XLEN +: XLEN];
                    end
                end
            end
        end else if (bus.flush) begin
            // PC/immediate still advance so a debugger can see what was squashed.
            valid_q <= 1'b0;
            pc_q    <= bus.pc_ID;
            imm_q   <= bus.imm_ID;
            rd_q    <= '0;
            rs_q    <= '0;
            op_q    <= '0;
        end else begin
            valid_q <= bus.valid_ID;
            pc_q    <= bus.pc_ID;
            imm_q   <= bus.imm_ID;
            rd_q    <= bus.valid_ID ? bus.rd_addr_ID : '0;
            rs_q    <= bus.rs_addr_ID;
            op_q    <= sel_data;
        end
    end

    assign bus.valid_EX   = valid_q;
    assign bus.pc_EX      = pc_q;
    assign bus.imm_EX     = imm_q;
    assign bus.rd_addr_EX = rd_q;
    assign bus.rs_addr_EX = rs_q;
    assign bus.op_EX      = op_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Scoreboard bench for idex_pipe_reg: directed cases then random traffic against a slot-level model.
module tb_idex_pipe_reg;
    import cpu_pipe_pkg::*;

    localparam int XLEN  = DEF_XLEN;
    localparam int RA_W  = DEF_RA_W;
    localparam int N_SRC = DEF_N_SRC;
    localparam int N_FWD = DEF_N_FWD;
    localparam int CW    = 64;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       imm;
        logic [RA_W-1:0]       rd;
        logic [N_SRC*RA_W-1:0] rs;
        logic [N_SRC*XLEN-1:0] op;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    idex_pipe_reg_if #(.XLEN(XLEN), .RA_W(RA_W), .N_SRC(N_SRC), .N_FWD(N_FWD)) bus ();

    idex_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .N_SRC(N_SRC), .N_FWD(N_FWD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    slot_t exp_q[$];
    slot_t m = '0;
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Monitor: the EX slot is presented every cycle; compare it once per clock.
    initial begin
        slot_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid_EX",   CW'(bus.valid_EX),   CW'(e.valid));
                chk("pc_EX",      CW'(bus.pc_EX),      CW'(e.pc));
                chk("imm_EX",     CW'(bus.imm_EX),     CW'(e.imm));
                chk("rd_addr_EX", CW'(bus.rd_addr_EX), CW'(e.rd));
                chk("rs_addr_EX", CW'(bus.rs_addr_EX), CW'(e.rs));
                chk("op_EX",      CW'(bus.op_EX),      CW'(e.op));
            end
        end
    end

    // Reference rule: youngest writing source with the same nonzero address supplies the value.
    function automatic int first_fwd(input logic [RA_W-1:0] a);
        for (int k = 0; k < N_FWD; k++) begin
            if (bus.fwd_we[k] && bus.fwd_addr[k*RA_W +: RA_W] == a && a != 0) return k;
        end
        return -1;
    endfunction

    task automatic set_rs(input int i, input logic [RA_W-1:0] a);
        bus.rs_addr_ID[i*RA_W +: RA_W] = a;
    endtask

    task automatic set_int(input int i, input logic [XLEN-1:0] d);
        bus.rs_int_ID[i*XLEN +: XLEN] = d;
    endtask

    task automatic set_fp(input int i, input logic [XLEN-1:0] d);
        bus.rs_fp_ID[i*XLEN +: XLEN] = d;
    endtask

    task automatic set_fwd(input int k, input logic we, input logic [RA_W-1:0] a, input logic [XLEN-1:0] d);
        bus.fwd_we[k]                = we;
        bus.fwd_addr[k*RA_W +: RA_W] = a;
        bus.fwd_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        #1;
        rst            = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.valid_ID   = 1'b1;
        bus.pc_ID      = $urandom;
        bus.imm_ID     = $urandom;
        bus.rd_addr_ID = '0;
        bus.rs_addr_ID = '0;
        bus.rs_int_ID  = '0;
        bus.rs_fp_ID   = '0;
        bus.fwd_we     = '0;
        bus.fwd_addr   = '0;
        bus.fwd_data   = '0;
    endtask

    task automatic end_cycle();
        int              k;
        logic [RA_W-1:0] a;
        if (rst) begin
            m = '0;
        end else if (bus.stall) begin
            if (m.valid) begin
                for (int i = 0; i < N_SRC; i++) begin
                    a = m.rs[i*RA_W +: RA_W];
                    k = first_fwd(a);
                    if (k >= 0) m.op[i*XLEN +: XLEN] = bus.fwd_data[k*XLEN +: XLEN];
                end
            end
        end else if (bus.flush) begin
            m.valid = 1'b0;
            m.pc    = bus.pc_ID;
            m.imm   = bus.imm_ID;
            m.rd    = '0;
            m.rs    = '0;
            m.op    = '0;
        end else begin
            m.valid = bus.valid_ID;
            m.pc    = bus.pc_ID;
            m.imm   = bus.imm_ID;
            m.rd    = bus.valid_ID ? bus.rd_addr_ID : '0;
            m.rs    = bus.rs_addr_ID;
            for (int i = 0; i < N_SRC; i++) begin
                a = bus.rs_addr_ID[i*RA_W +: RA_W];
                k = first_fwd(a);
                if (k >= 0)             m.op[i*XLEN +: XLEN] = bus.fwd_data[k*XLEN +: XLEN];
                else if (a[RA_W-1])     m.op[i*XLEN +: XLEN] = bus.rs_fp_ID[i*XLEN +: XLEN];
                else                    m.op[i*XLEN +: XLEN] = bus.rs_int_ID[i*XLEN +: XLEN];
            end
        end
        exp_q.push_back(m);
        if (rst) begin
            // Reset must act before any clock edge arrives.
            #1;
            chk("async_rst_valid", CW'(bus.valid_EX), CW'(m.valid));
            chk("async_rst_pc",    CW'(bus.pc_EX),    CW'(m.pc));
            chk("async_rst_op",    CW'(bus.op_EX),    CW'(m.op));
        end
        cyc++;
    endtask

    function automatic logic [RA_W-1:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return RA_W'(0);
            1:       return RA_W'(3);
            2:       return RA_W'(7);
            3:       return RA_W'('h20);
            4:       return RA_W'('h21);
            default: return RA_W'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) begin
            begin_cycle(); rst = 1'b1; end_cycle();
        end

        // Plain load from the integer file.
        begin_cycle();
        bus.pc_ID = 32'h100; bus.imm_ID = 32'h4; bus.rd_addr_ID = 6'd5;
        set_rs(0, 6'd1); set_rs(1, 6'd2); set_int(0, 32'h11); set_int(1, 32'h22);
        end_cycle();

        // Forward priority, then the lower-priority source alone.
        begin_cycle(); set_rs(0, 6'd3); set_fwd(0, 1'b1, 6'd3, 32'hAAAA); set_fwd(1, 1'b1, 6'd3, 32'hBBBB); end_cycle();
        begin_cycle(); set_rs(0, 6'd3); set_fwd(0, 1'b0, 6'd3, 32'hAAAA); set_fwd(1, 1'b1, 6'd3, 32'hBBBB); end_cycle();

        // x0 never forwards; FP select; FP f0 forwards.
        begin_cycle();
        set_rs(0, 6'd0); set_fwd(0, 1'b1, 6'd0, 32'hDEAD);
        set_rs(1, 6'h21); set_fp(1, 32'h3F800000); set_int(1, 32'h99);
        end_cycle();
        begin_cycle(); set_rs(0, 6'h20); set_fwd(0, 1'b1, 6'h20, 32'h5); set_int(0, 32'h66); end_cycle();

        // Stale operand refreshed mid-stall, then held.
        begin_cycle(); set_rs(0, 6'd7); set_int(0, 32'h1); bus.rd_addr_ID = 6'd9; end_cycle();
        for (int s = 0; s < 3; s++) begin
            begin_cycle(); bus.stall = 1'b1;
            if (s == 1) set_fwd(1, 1'b1, 6'd7, 32'h77);
            end_cycle();
        end
        begin_cycle(); bus.stall = 1'b1; bus.flush = 1'b1; end_cycle();

        // Flush loads a bubble.
        begin_cycle(); bus.flush = 1'b1; set_rs(0, 6'd3); set_int(0, 32'h5); bus.rd_addr_ID = 6'd4; end_cycle();

        // Stalled bubble ignores a matching forward.
        begin_cycle(); bus.valid_ID = 1'b0; set_rs(0, 6'd9); set_int(0, 32'h12); bus.rd_addr_ID = 6'd6; end_cycle();
        begin_cycle(); bus.stall = 1'b1; set_fwd(0, 1'b1, 6'd9, 32'hF00D); end_cycle();

        // Reset landing in the middle of a stall.
        begin_cycle(); set_rs(0, 6'd1); set_int(0, 32'h3); bus.rd_addr_ID = 6'd2; end_cycle();
        begin_cycle(); bus.stall = 1'b1; rst = 1'b1; end_cycle();

        for (int n = 0; n < 400; n++) begin
            begin_cycle();
            rst            = ($urandom_range(0, 63) == 0);
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.flush      = ($urandom_range(0, 7) == 0);
            bus.valid_ID   = ($urandom_range(0, 3) != 0);
            bus.rd_addr_ID = RA_W'($urandom);
            for (int i = 0; i < N_SRC; i++) begin
                set_rs(i, pick_addr());
                set_int(i, $urandom);
                set_fp(i, $urandom);
            end
            for (int k = 0; k < N_FWD; k++) begin
                set_fwd(k, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
            end
            end_cycle();
        end

        begin_cycle(); end_cycle();
        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard_drained", CW'(exp_q.size()), CW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
